dot_scan_controller: RTL

- Upstream timing stage for dot_sequencer.
- Walks row_select/col_select across a configurable row×column window.
- Holds each address one settle cycle, then samples the sequencer's firing_bit/firing_data.
- Emits a timed drive pulse per dot, followed by a programmable gap; signals frame completion and optionally loops.

---
 rtl/dot_scan_pkg.sv | 18 +
 rtl/dot_scan_controller_if.sv | 32 +++
 rtl/dot_scan_timer.sv | 42 ++++
 rtl/dot_scan_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dot_scan_pkg.sv
// Shared types and default sizing for the dot scan controller and the
// dot_sequencer it addresses. DEFAULT_MEM_LENGTH and DEFAULT_MEM_ADDRESS_LENGTH
// must stay in step with dot_sequencer.
package dot_scan_pkg;

  localparam int DEFAULT_MEM_LENGTH         = 48;
  localparam int DEFAULT_MEM_ADDRESS_LENGTH = 6;
  localparam int DEFAULT_TIMER_WIDTH        = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP,
    ADVANCE
  } state_e;

endpackage

// File: rtl/dot_scan_controller_if.sv
// Address/read bus between the scan controller (master) and the
// dot_sequencer (slave). The sequencer answers combinationally from
// row_select/col_select/row_col_select with firing_bit/firing_data.
interface dot_scan_controller_if
  import dot_scan_pkg::*;
#(
  parameter int MEM_ADDRESS_LENGTH = DEFAULT_MEM_ADDRESS_LENGTH
);

  logic [MEM_ADDRESS_LENGTH-1:0] row_select;
  logic [MEM_ADDRESS_LENGTH-1:0] col_select;
  logic                          row_col_select;
  logic                          firing_bit;
  logic                          firing_data;

  modport master (
    output row_select,
    output col_select,
    output row_col_select,
    input  firing_bit,
    input  firing_data
  );

  modport slave (
    input  row_select,
    input  col_select,
    input  row_col_select,
    output firing_bit,
    output firing_data
  );

endinterface

// File: rtl/dot_scan_timer.sv
// Loadable down-counter shared by the PULSE and GAP phases. Loading N-1
// makes done_o rise after N cycles of the phase; the count parks at zero.
module dot_scan_timer
  import dot_scan_pkg::*;
#(
  parameter int TIMER_WIDTH = DEFAULT_TIMER_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load_i,
  input  logic [TIMER_WIDTH-1:0] load_val_i,
  input  logic                   en_i,
  output logic                   done_o
);

  logic [TIMER_WIDTH-1:0] count_q;
  logic [TIMER_WIDTH-1:0] count_d;

  // Next count: a load wins over a decrement; never wraps below zero.
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - TIMER_WIDTH'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking so every flop samples pre-edge values, whatever the block order.
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/dot_scan_controller.sv
// Upstream timing stage for dot_sequencer: walks a row x column window
// (column inner), holds each address one settle cycle, samples the
// sequencer's firing_bit/firing_data, then drives a timed pulse and an
// optional gap per dot. Signals frame end and can loop.
// Optional build macro DOT_SCAN_SKIP_EN: dots whose firing_bit is 0 skip
// PULSE/GAP and cost two cycles instead of a silent full-length slot.
module dot_scan_controller
  import dot_scan_pkg::*;
#(
  parameter int MEM_LENGTH         = DEFAULT_MEM_LENGTH,
  parameter int MEM_ADDRESS_LENGTH = DEFAULT_MEM_ADDRESS_LENGTH,
  parameter int TIMER_WIDTH        = DEFAULT_TIMER_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop_en,
  input  logic                          row_col_mode,
  input  logic [MEM_ADDRESS_LENGTH-1:0] row_limit,
  input  logic [MEM_ADDRESS_LENGTH-1:0] col_limit,
  input  logic [TIMER_WIDTH-1:0]        pulse_width,
  input  logic [TIMER_WIDTH-1:0]        gap_width,
  dot_scan_controller_if.master         seq,
  output logic                          drive_en,
  output logic                          drive_data,
  output logic                          busy,
  output logic                          frame_done
);

  localparam logic [MEM_ADDRESS_LENGTH-1:0] LIMIT_MAX = MEM_ADDRESS_LENGTH'(MEM_LENGTH - 1);
  localparam logic [MEM_ADDRESS_LENGTH-1:0] ADDR_ONE  = MEM_ADDRESS_LENGTH'(1);
  localparam logic [TIMER_WIDTH-1:0]        TIMER_ONE = TIMER_WIDTH'(1);

  state_e                        state_q;
  logic [MEM_ADDRESS_LENGTH-1:0] row_q, col_q;
  logic [MEM_ADDRESS_LENGTH-1:0] row_limit_q, col_limit_q;
  logic [MEM_ADDRESS_LENGTH-1:0] row_limit_d, col_limit_d;
  logic [TIMER_WIDTH-1:0]        pulse_width_q, gap_width_q;
  logic [TIMER_WIDTH-1:0]        pulse_width_d;
  logic                          row_col_q;
  logic                          drive_en_q, drive_data_q, frame_done_q;

  logic                          tmr_load, tmr_en, tmr_done;
  logic [TIMER_WIDTH-1:0]        tmr_val;
  logic                          last_dot;

  // Sanitised config captured at start and at each loop restart.
  always_comb begin
    row_limit_d   = (row_limit > LIMIT_MAX) ? LIMIT_MAX : row_limit;
    col_limit_d   = (col_limit > LIMIT_MAX) ? LIMIT_MAX : col_limit;
    pulse_width_d = (pulse_width == '0) ? TIMER_ONE : pulse_width;
  end

  assign last_dot = (col_q == col_limit_q) && (row_q == row_limit_q);

  // Timer control: arm the pulse length in SETUP, the gap length on PULSE exit.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = pulse_width_q - TIMER_ONE;
    if (state_q == SETUP) begin
      tmr_load = 1'b1;
    end else if ((state_q == PULSE) && tmr_done && (gap_width_q != '0)) begin
      tmr_load = 1'b1;
      tmr_val  = gap_width_q - TIMER_ONE;
    end
  end

  assign tmr_en = (state_q == PULSE) || (state_q == GAP);

  dot_scan_timer #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  // Scan FSM, address walker and registered drive/frame outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      row_q         <= '0;
      col_q         <= '0;
      row_limit_q   <= '0;
      col_limit_q   <= '0;
      pulse_width_q <= '0;
      gap_width_q   <= '0;
      row_col_q     <= 1'b0;
      drive_en_q    <= 1'b0;
      drive_data_q  <= 1'b0;
      frame_done_q  <= 1'b0;
    end else if (stop) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      drive_en_q   <= 1'b0;
      drive_data_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            row_limit_q   <= row_limit_d;
            col_limit_q   <= col_limit_d;
            pulse_width_q <= pulse_width_d;
            gap_width_q   <= gap_width;
            row_col_q     <= row_col_mode;
            row_q         <= '0;
            col_q         <= '0;
            state_q       <= SETUP;
          end
        end
        SETUP: begin
`ifdef DOT_SCAN_SKIP_EN
          if (!seq.firing_bit) begin
            drive_data_q <= 1'b0;
            frame_done_q <= last_dot;
            state_q      <= ADVANCE;
          end else begin
            drive_en_q   <= 1'b1;
            drive_data_q <= seq.firing_data;
            state_q      <= PULSE;
          end
`else
          drive_en_q   <= seq.firing_bit;
          drive_data_q <= seq.firing_data;
          state_q      <= PULSE;
`endif
        end
        PULSE: begin
          if (tmr_done) begin
            drive_en_q   <= 1'b0;
            drive_data_q <= 1'b0;
            if (gap_width_q != '0) begin
              state_q <= GAP;
            end else begin
              frame_done_q <= last_dot;
              state_q      <= ADVANCE;
            end
          end
        end
        GAP: begin
          if (tmr_done) begin
            frame_done_q <= last_dot;
            state_q      <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (col_q < col_limit_q) begin
            col_q   <= col_q + ADDR_ONE;
            state_q <= SETUP;
          end else begin
            col_q <= '0;
            if (row_q < row_limit_q) begin
              row_q   <= row_q + ADDR_ONE;
              state_q <= SETUP;
            end else begin
              row_q <= '0;
              if (loop_en) begin
                row_limit_q   <= row_limit_d;
                col_limit_q   <= col_limit_d;
                pulse_width_q <= pulse_width_d;
                gap_width_q   <= gap_width;
                row_col_q     <= row_col_mode;
                state_q       <= SETUP;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign seq.row_select     = row_q;
  assign seq.col_select     = col_q;
  assign seq.row_col_select = row_col_q;
  assign drive_en           = drive_en_q;
  assign drive_data         = drive_data_q;
  assign frame_done         = frame_done_q;
  assign busy               = (state_q != IDLE);

endmodule
